// File: rtl/apb_pkg.sv
// apb_pkg: shared widths, peripheral window defaults and bridge FSM state type.
package apb_pkg;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam logic [31:0] DEF_APB_BASE = 32'h9300_0000;
    localparam logic [31:0] DEF_APB_SIZE = 32'h0001_0000;
    localparam logic [31:0] GPIO_BASE = 32'h9300_0000;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_bridge_state_t;
endpackage

// File: rtl/apb_bridge_if.sv
// apb_bridge_if: core request/response channel plus APB master signals of the bridge.
interface apb_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic req_valid;
    logic req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic req_write;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic resp_valid;
    logic resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic resp_err;
    logic PSEL;
    logic PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic PREADY;
    logic PSLVERR;
    modport slave (
        input req_valid, req_addr, req_write, req_wdata, resp_ready, PRDATA, PREADY, PSLVERR,
        output req_ready, resp_valid, resp_rdata, resp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
    modport master (
        output req_valid, req_addr, req_write, req_wdata, resp_ready, PRDATA, PREADY, PSLVERR,
        input req_ready, resp_valid, resp_rdata, resp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_bridge.sv
// apb_bridge: single-outstanding valid/ready to APB bridge with local rejection of out-of-window addresses.
// Optional ACCESS-phase timeout compiled in with APB_BRIDGE_TIMEOUT_EN.
module apb_bridge
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] APB_BASE = DEF_APB_BASE,
    parameter logic [ADDR_WIDTH-1:0] APB_SIZE = DEF_APB_SIZE,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic clk,
    input logic arst,
    apb_bridge_if.slave bus
);
    apb_bridge_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic pwrite_q, pwrite_d, err_q, err_d;
    logic in_win, timeout;
    // One extra bit keeps APB_BASE+APB_SIZE from wrapping at the top of the address space.
    assign in_win = ({1'b0, bus.req_addr} >= {1'b0, APB_BASE}) &&
                    ({1'b0, bus.req_addr} < ({1'b0, APB_BASE} + {1'b0, APB_SIZE}));
`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (state_q == ACCESS && !bus.PREADY) ? cnt_q + CW'(1) : '0;
    assign timeout = state_q == ACCESS && !bus.PREADY && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge arst) begin
        if (arst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        paddr_d = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d = rdata_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                if (in_win) begin
                    paddr_d = bus.req_addr;
                    pwrite_d = bus.req_write;
                    pwdata_d = bus.req_wdata;
                    state_d = SETUP;
                end else begin
                    rdata_d = '0;
                    err_d = 1'b1;
                    state_d = RESP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (bus.PREADY) begin
                rdata_d = (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
                err_d = bus.PSLVERR;
                state_d = RESP;
            end else if (timeout) begin
                rdata_d = '0;
                err_d = 1'b1;
                state_d = RESP;
            end
            default: state_d = bus.resp_ready ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            paddr_q <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            paddr_q <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
        end
    end
    // Strobes decode from state so an asynchronous reset drops them at once.
    assign bus.req_ready = state_q == IDLE;
    assign bus.resp_valid = state_q == RESP;
    assign bus.PSEL = state_q == SETUP || state_q == ACCESS;
    assign bus.PENABLE = state_q == ACCESS;
    assign bus.PADDR = paddr_q;
    assign bus.PWRITE = pwrite_q;
    assign bus.PWDATA = pwdata_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err = err_q;
endmodule

// File: tb/tb_apb_bridge.sv
// tb_apb_bridge: directed checks of the APB bridge against a small wait-state APB slave.
module tb_apb_bridge;
    import apb_pkg::*;
    logic clk = 1'b0;
    logic arst = 1'b1;
    int passed = 0;
    int total = 0;
    int lat, acc;
    bit psel_seen;
    int ws = 0;
    int wcnt = 0;
    bit stuck = 1'b0;
    bit slverr = 1'b0;
    logic [31:0] mem [2];
    logic [31:0] hold_rdata;

    apb_bridge_if bus ();
    apb_bridge dut (.clk(clk), .arst(arst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.PREADY = !stuck && (wcnt >= ws);
    assign bus.PRDATA = bus.PADDR[3] ? 32'hA5A5_0001 : mem[bus.PADDR[2]];
    assign bus.PSLVERR = slverr;
    always @(posedge clk) begin
        wcnt <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? wcnt + 1 : 0;
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR[2]] <= bus.PWDATA;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        bus.req_write = w;
        bus.req_wdata = d;
        cyc();
        bus.req_valid = 1'b0;
        lat = 1;
        acc = int'(bus.PENABLE);
        psel_seen = bus.PSEL;
    endtask

    task automatic wait_resp(input int bound);
        while (!bus.resp_valid && lat < bound) begin
            cyc();
            lat++;
            acc += int'(bus.PENABLE);
            psel_seen |= bus.PSEL;
        end
    endtask

    task automatic ack();
        bus.resp_ready = 1'b1;
        cyc();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) $display("FAIL rst_strobes: got %b%b want 00", bus.PSEL, bus.PENABLE); else passed++;
        total++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.PWRITE !== 1'b0) $display("FAIL rst_flags: got %b%b%b want 000", bus.resp_valid, bus.resp_err, bus.PWRITE); else passed++;
        total++; if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0 || bus.resp_rdata !== 32'h0) $display("FAIL rst_data: got %h %h %h want zeros", bus.PADDR, bus.PWDATA, bus.resp_rdata); else passed++;
        cyc();
        arst = 1'b0;
        cyc();
        total++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.req_ready); else passed++;
    endtask

    task automatic test_write_fast();
        ws = 0;
        send(GPIO_BASE, 1'b1, 32'hFFFF_FFFF);
        total++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0) $display("FAIL wr_setup: got %b%b want 10", bus.PSEL, bus.PENABLE); else passed++;
        total++; if (bus.PADDR !== 32'h9300_0000 || bus.PWRITE !== 1'b1 || bus.PWDATA !== 32'hFFFF_FFFF) $display("FAIL wr_bus: got %h %b %h want 93000000 1 ffffffff", bus.PADDR, bus.PWRITE, bus.PWDATA); else passed++;
        total++; if (bus.req_ready !== 1'b0) $display("FAIL wr_busy: got %b want 0", bus.req_ready); else passed++;
        cyc();
        lat++;
        total++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) $display("FAIL wr_access: got %b%b want 11", bus.PSEL, bus.PENABLE); else passed++;
        wait_resp(60);
        total++; if (lat !== 3) $display("FAIL wr_lat: got %0d want 3", lat); else passed++;
        total++; if (bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.PSEL !== 1'b0) $display("FAIL wr_resp: got err=%b rdata=%h psel=%b want 0 0 0", bus.resp_err, bus.resp_rdata, bus.PSEL); else passed++;
        ack();
        send(GPIO_BASE, 1'b0, 32'h0);
        wait_resp(60);
        total++; if (lat !== 3 || bus.resp_rdata !== 32'hFFFF_FFFF) $display("FAIL wr_readback: got lat=%0d rdata=%h want 3 ffffffff", lat, bus.resp_rdata); else passed++;
        ack();
    endtask

    task automatic test_wait_states();
        ws = 2;
        send(32'h9300_0008, 1'b0, 32'h0);
        wait_resp(60);
        total++; if (lat !== 5) $display("FAIL ws_lat: got %0d want 5", lat); else passed++;
        total++; if (acc !== 3) $display("FAIL ws_access_cycles: got %0d want 3", acc); else passed++;
        total++; if (bus.resp_rdata !== 32'hA5A5_0001 || bus.resp_err !== 1'b0) $display("FAIL ws_rdata: got %h err=%b want a5a50001 0", bus.resp_rdata, bus.resp_err); else passed++;
        ack();
        ws = 0;
    endtask

    task automatic test_out_of_window();
        logic [31:0] addrs [4] = '{32'h8000_0000, 32'h9301_0000, 32'h92FF_FFFC, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            send(addrs[i], 1'b0, 32'h0);
            wait_resp(60);
            total++; if (lat !== 1 || psel_seen !== 1'b0) $display("FAIL oow_lat[%0d]: got lat=%0d psel=%b want 1 0", i, lat, psel_seen); else passed++;
            total++; if (bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0) $display("FAIL oow_resp[%0d]: got err=%b rdata=%h want 1 0", i, bus.resp_err, bus.resp_rdata); else passed++;
            ack();
        end
        send(32'h9300_FFFC, 1'b0, 32'h0);
        wait_resp(60);
        total++; if (lat !== 3 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'hA5A5_0001) $display("FAIL win_top: got lat=%0d err=%b rdata=%h want 3 0 a5a50001", lat, bus.resp_err, bus.resp_rdata); else passed++;
        ack();
    endtask

    task automatic test_slverr_hold();
        slverr = 1'b1;
        send(GPIO_BASE, 1'b0, 32'h0);
        wait_resp(60);
        total++; if (lat !== 3 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0) $display("FAIL err_resp: got lat=%0d err=%b rdata=%h want 3 1 0", lat, bus.resp_err, bus.resp_rdata); else passed++;
        slverr = 1'b0;
        hold_rdata = bus.resp_rdata;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== hold_rdata) $display("FAIL err_hold[%0d]: got v=%b err=%b rdata=%h want 1 1 %h", i, bus.resp_valid, bus.resp_err, bus.resp_rdata, hold_rdata); else passed++;
            total++; if (bus.req_ready !== 1'b0 || bus.PSEL !== 1'b0) $display("FAIL err_busy[%0d]: got ready=%b psel=%b want 0 0", i, bus.req_ready, bus.PSEL); else passed++;
            cyc();
        end
        ack();
        total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) $display("FAIL err_release: got ready=%b v=%b want 1 0", bus.req_ready, bus.resp_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        send(32'h9300_0004, 1'b1, 32'h0000_00C3);
        wait_resp(60);
        ack();
        total++; if (bus.PSEL !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL b2b_gap: got psel=%b ready=%b want 0 1", bus.PSEL, bus.req_ready); else passed++;
        send(32'h9300_0004, 1'b0, 32'h0);
        total++; if (bus.PSEL !== 1'b1) $display("FAIL b2b_accept: got psel=%b want 1", bus.PSEL); else passed++;
        wait_resp(60);
        total++; if (lat !== 3 || bus.resp_rdata !== 32'h0000_00C3) $display("FAIL b2b_read: got lat=%0d rdata=%h want 3 000000c3", lat, bus.resp_rdata); else passed++;
        ack();
    endtask

    task automatic test_reset_mid();
        stuck = 1'b1;
        send(32'h9300_0008, 1'b0, 32'h0);
        cyc();
        total++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) $display("FAIL arst_pre: got %b%b want 11", bus.PSEL, bus.PENABLE); else passed++;
        #2 arst = 1'b1;
        #1;
        total++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) $display("FAIL arst_async: got %b%b want 00", bus.PSEL, bus.PENABLE); else passed++;
        #2 arst = 1'b0;
        stuck = 1'b0;
        cyc();
        total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.PSEL !== 1'b0) $display("FAIL arst_after: got ready=%b v=%b psel=%b want 1 0 0", bus.req_ready, bus.resp_valid, bus.PSEL); else passed++;
    endtask

`ifdef APB_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        stuck = 1'b1;
        send(32'h9300_0008, 1'b0, 32'h0);
        wait_resp(60);
        total++; if (lat !== 18 || acc !== 16) $display("FAIL to_lat: got lat=%0d access=%0d want 18 16", lat, acc); else passed++;
        total++; if (bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.PSEL !== 1'b0) $display("FAIL to_resp: got err=%b rdata=%h psel=%b want 1 0 0", bus.resp_err, bus.resp_rdata, bus.PSEL); else passed++;
        ack();
        stuck = 1'b0;
        send(GPIO_BASE, 1'b1, 32'h1234_5678);
        wait_resp(60);
        total++; if (lat !== 3 || bus.resp_err !== 1'b0) $display("FAIL to_next: got lat=%0d err=%b want 3 0", lat, bus.resp_err); else passed++;
        ack();
    endtask
`else
    task automatic test_no_timeout();
        stuck = 1'b1;
        send(32'h9300_0008, 1'b0, 32'h0);
        wait_resp(30);
        total++; if (bus.resp_valid !== 1'b0 || bus.PENABLE !== 1'b1) $display("FAIL nto_wait: got v=%b pen=%b want 0 1", bus.resp_valid, bus.PENABLE); else passed++;
        stuck = 1'b0;
        wait_resp(60);
        total++; if (lat !== 31 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'hA5A5_0001) $display("FAIL nto_done: got lat=%0d err=%b rdata=%h want 31 0 a5a50001", lat, bus.resp_err, bus.resp_rdata); else passed++;
        ack();
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_write_fast();
        test_wait_states();
        test_out_of_window();
        test_slverr_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef APB_BRIDGE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
